mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//   Shares the CPU's single memory bus between instruction fetch (IF) and load/store (MEM).
//   Holds at most one bus transaction in flight, with a valid/ready request and a response strobe.
//   Generates if_stall and mem_stall, which feed the hazard/stall controller.
//   Discards a fetch response whose fetch was flushed by a taken jump.
// PARAMETERS
//   ADDR_W       32   address width
//   DATA_W       32   data width
//   TIMEOUT_CYC  255  max cycles in WAIT before forced completion with error
// PORTS
//   clk            in   1         clock; all state updates on the rising edge
//   rst            in   1         asynchronous reset, active-high
//   if_req         in   1         fetch request; held until if_stall falls
//   if_addr        in   ADDR_W    fetch address; sampled at grant
//   if_rdata       out  DATA_W    fetched word; valid in the cycle if_stall falls
//   if_stall       out  1         fetch not yet complete
//   flush_if       in   1         taken jump; drops the in-flight fetch
//   mem_req        in   1         load/store request; held until mem_stall falls
//   mem_we         in   1         1 = store
//   mem_addr       in   ADDR_W    load/store address
//   mem_wdata      in   DATA_W    store data
//   mem_wstrb      in   DATA_W/8  byte enables (store)
//   mem_rdata      out  DATA_W    load data; valid in the cycle mem_stall falls
//   mem_stall      out  1         load/store not yet complete
//   bus_req_valid  out  1         request valid to memory
//   bus_req_ready  in   1         memory accepts request
//   bus_addr       out  ADDR_W    registered request address
//   bus_we         out  1         registered write flag (0 for IF)
//   bus_wdata      out  DATA_W    registered store data
//   bus_wstrb      out  DATA_W/8  registered strobes (0 for IF)
//   bus_resp_valid in   1         one-cycle response strobe
//   bus_rdata      in   DATA_W    response data
//   bus_err        out  1         sticky timeout flag
// BEHAVIOUR
//   Reset values
//     - state=IDLE, owner=IF, drop=0, timeout counter=0.
//     - bus_req_valid=0, bus_addr/wdata/wstrb/we=0, bus_err=0.
//     - Stall outputs follow their request inputs.
//   States
//     - IDLE: grant when a request is present; mem_req beats if_req (older instruction).
//       Latch owner, address, we, wdata and wstrb, then go to REQ.
//     - REQ: bus_req_valid=1 and bus_* held stable; bus_req_ready -> WAIT.
//     - WAIT: on bus_resp_valid -> IDLE.
//   Grants are issued only from IDLE, so back-to-back transactions have a 1-cycle bubble.
//   Minimum latency: request at cycle 0 -> valid at 1 -> ready at 1 -> response at 2.
//   done = (state==WAIT) & bus_resp_valid.
//   Stalls
//     - if_stall = if_req & ~(done & owner==IF & ~drop).
//     - mem_stall = mem_req & ~(done & owner==MEM).
//   Read data
//     - if_rdata and mem_rdata pass bus_rdata combinationally.
//     - Both are forced to 0 when the completion is a timeout.
//   Flush
//     - flush_if while owner==IF in REQ or WAIT sets drop.
//     - A REQ is never retracted; it completes on the bus.
//     - A dropped response returns to IDLE with no IF completion; drop is cleared.
//     - flush_if in IDLE, or with owner==MEM, has no effect.
//   Flush in the same cycle as the IF response: the response is dropped.
//   A bus_resp_valid seen in IDLE or REQ is ignored.
//   Timeout
//     - The counter runs only in WAIT.
//     - Reaching TIMEOUT_CYC is treated as done with rdata=0; bus_err is set.
//     - bus_err is cleared by reset only.
//   Reset mid-transaction aborts immediately; a late response after reset is ignored (IDLE).
// STRUCTURE
//   cpu_pkg
//     - state encoding IDLE=2'd0, REQ=2'd1, WAIT=2'd2.
//     - owner encoding OWN_IF=1'b0, OWN_MEM=1'b1.
//   Sub-module mem_timeout_cnt: counter with clear/enable inputs and an expire output.
// TESTING
//   1. if_req only, addr 0x100, ready at once, response 1 cycle later with 0x00000013
//      -> if_stall falls at cycle 2, if_rdata=0x13.
//   2. if_req and mem_req together in IDLE, mem_we=1, addr 0x2000, wstrb 4'hF
//      -> MEM granted first (bus_we=1); IF granted after a 1-cycle bubble.
//   3. flush_if in WAIT with owner IF -> response ignored, if_stall stays high;
//      new if_addr 0x200 is granted next.
//   4. bus_req_ready held low for 5 cycles
//      -> bus_req_valid and bus_addr stay constant for all 5 cycles.
//   5. No response, TIMEOUT_CYC=8 -> mem_stall falls 8 cycles into WAIT,
//      mem_rdata=0, bus_err=1 and stays 1.
//   6. rst in WAIT, response strobe 1 cycle later
//      -> no stall release, bus_req_valid=0, state=IDLE.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types for the CPU memory-port arbiter: FSM state and bus owner encodings.
package cpu_pkg;

  // Arbiter FSM states. Encoding value 2'd3 is unused and recovers to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } arb_state_e;

  // Which requester owns the transaction currently on the bus.
  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } arb_owner_e;

  // True while a transaction is held on the bus (requested or awaiting response).
  function automatic logic is_busy(input arb_state_e st);
    return (st == ST_REQ) || (st == ST_WAIT);
  endfunction

endpackage

// File: rtl/mem_timeout_cnt.sv
// Response timeout counter. Counts cycles while enabled and flags the cycle in
// which the TIMEOUT_CYC-th enabled cycle is reached. Clearing restarts at zero.
module mem_timeout_cnt #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  // The count holds 0..TIMEOUT_CYC-1; value k means k earlier enabled cycles.
  localparam int unsigned CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_r;
  logic             last_s;

  assign last_s = (cnt_r == LAST_CNT);
  assign expire = en & ~clr & last_s;

  // Count enabled cycles, saturating at the last value; clear has priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (en && !last_s) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Memory-port arbiter: shares one memory bus between instruction fetch (IF)
// and load/store (MEM). One transaction in flight at a time; MEM wins ties.
// A fetch flushed by a taken jump still completes on the bus, but its
// response is swallowed so the fetch stage keeps stalling for the new target.
module mem_port_arbiter
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                clk,
  input  logic                rst,
  // fetch side
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_stall,
  input  logic                flush_if,
  // load/store side
  input  logic                mem_req,
  input  logic                mem_we,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W/8-1:0] mem_wstrb,
  output logic [DATA_W-1:0]   mem_rdata,
  output logic                mem_stall,
  // memory bus
  output logic                bus_req_valid,
  input  logic                bus_req_ready,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic                bus_we,
  output logic [DATA_W-1:0]   bus_wdata,
  output logic [DATA_W/8-1:0] bus_wstrb,
  input  logic                bus_resp_valid,
  input  logic [DATA_W-1:0]   bus_rdata,
  output logic                bus_err
);

  localparam int unsigned STRB_W = DATA_W / 8;

  arb_state_e          state_r, state_nxt_s;
  arb_owner_e          owner_r, owner_nxt_s;
  logic                drop_r, drop_nxt_s;
  logic                load_s;

  logic [ADDR_W-1:0]   addr_r;
  logic                we_r;
  logic [DATA_W-1:0]   wdata_r;
  logic [STRB_W-1:0]   wstrb_r;
  logic                bus_err_r;

  logic                in_wait_s;
  logic                expire_s;
  logic                done_s;
  logic                timeout_s;
  logic                flush_hit_s;
  logic                drop_eff_s;
  logic                if_done_s;
  logic                mem_done_s;

  assign in_wait_s = (state_r == ST_WAIT);

  // Timeout only counts cycles spent waiting for the response.
  mem_timeout_cnt #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clr    (~in_wait_s),
    .en     (in_wait_s),
    .expire (expire_s)
  );

  // A response strobe outside WAIT is stray and ignored. A real response in
  // the expiry cycle wins over the timeout, so its data is still delivered.
  assign done_s    = in_wait_s & (bus_resp_valid | expire_s);
  assign timeout_s = in_wait_s & expire_s & ~bus_resp_valid;

  // A flush landing in the completion cycle must also drop that response.
  assign flush_hit_s = flush_if & (owner_r == OWN_IF) & is_busy(state_r);
  assign drop_eff_s  = drop_r | flush_hit_s;

  assign if_done_s  = done_s & (owner_r == OWN_IF) & ~drop_eff_s;
  assign mem_done_s = done_s & (owner_r == OWN_MEM);

  // Next-state, owner selection and drop tracking.
  always_comb begin
    state_nxt_s = state_r;
    owner_nxt_s = owner_r;
    drop_nxt_s  = drop_r;
    load_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        drop_nxt_s = 1'b0;
        if (mem_req) begin
          state_nxt_s = ST_REQ;
          owner_nxt_s = OWN_MEM;
          load_s      = 1'b1;
        end else if (if_req) begin
          state_nxt_s = ST_REQ;
          owner_nxt_s = OWN_IF;
          load_s      = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        drop_nxt_s = drop_eff_s;
        if (bus_req_ready) begin
          state_nxt_s = ST_WAIT;
        end else begin
          state_nxt_s = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (done_s) begin
          state_nxt_s = ST_IDLE;
          drop_nxt_s  = 1'b0;
        end else begin
          state_nxt_s = ST_WAIT;
          drop_nxt_s  = drop_eff_s;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        drop_nxt_s  = 1'b0;
      end
    endcase
  end

  // FSM, owner and drop registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      owner_r <= OWN_IF;
      drop_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      owner_r <= owner_nxt_s;
      drop_r  <= drop_nxt_s;
    end
  end

  // Capture the granted request; held stable until the next grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_r  <= {ADDR_W{1'b0}};
      we_r    <= 1'b0;
      wdata_r <= {DATA_W{1'b0}};
      wstrb_r <= {STRB_W{1'b0}};
    end else if (load_s) begin
      if (owner_nxt_s == OWN_MEM) begin
        addr_r  <= mem_addr;
        we_r    <= mem_we;
        wdata_r <= mem_wdata;
        wstrb_r <= mem_wstrb;
      end else begin
        addr_r  <= if_addr;
        we_r    <= 1'b0;
        wdata_r <= {DATA_W{1'b0}};
        wstrb_r <= {STRB_W{1'b0}};
      end
    end else begin
      addr_r  <= addr_r;
      we_r    <= we_r;
      wdata_r <= wdata_r;
      wstrb_r <= wstrb_r;
    end
  end

  // Sticky timeout flag; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_err_r <= 1'b0;
    end else begin
      bus_err_r <= bus_err_r | timeout_s;
    end
  end

  // Read data passes straight through except on a timeout completion.
  always_comb begin
    if_rdata  = {DATA_W{1'b0}};
    mem_rdata = {DATA_W{1'b0}};
    if (timeout_s) begin
      if_rdata  = {DATA_W{1'b0}};
      mem_rdata = {DATA_W{1'b0}};
    end else begin
      if_rdata  = bus_rdata;
      mem_rdata = bus_rdata;
    end
  end

  assign if_stall      = if_req  & ~if_done_s;
  assign mem_stall     = mem_req & ~mem_done_s;

  assign bus_req_valid = (state_r == ST_REQ);
  assign bus_addr      = addr_r;
  assign bus_we        = we_r;
  assign bus_wdata     = wdata_r;
  assign bus_wstrb     = wstrb_r;
  assign bus_err       = bus_err_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed vector table, hand sequences for
// stall/timeout/reset corners, then randomized traffic against a memory model.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, flush_if, mem_req, mem_we;
  logic [AW-1:0] if_addr, mem_addr, bus_addr;
  logic [DW-1:0] if_rdata, mem_rdata, mem_wdata, bus_wdata, bus_rdata;
  logic [3:0]    mem_wstrb, bus_wstrb;
  logic          if_stall, mem_stall, bus_req_valid, bus_req_ready;
  logic          bus_we, bus_resp_valid, bus_err;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_stall(if_stall),
    .flush_if(flush_if),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_stall(mem_stall),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_addr(bus_addr),
    .bus_we(bus_we), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .bus_resp_valid(bus_resp_valid), .bus_rdata(bus_rdata), .bus_err(bus_err)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  task automatic clear_inputs();
    if_req = 1'b0; if_addr = '0; flush_if = 1'b0;
    mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
    bus_req_ready = 1'b0; bus_resp_valid = 1'b0; bus_rdata = '0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic ifr; logic [31:0] ifa; logic fl;
    logic mr; logic mw; logic [31:0] ma;
    logic rdy; logic rv; logic [31:0] rd;
    logic e_ifs; logic e_ms; logic e_v; logic [31:0] e_addr; logic e_we;
  } vec_t;

  function automatic vec_t mk(logic ifr, logic [31:0] ifa, logic fl, logic mr, logic mw,
                              logic [31:0] ma, logic rdy, logic rv, logic [31:0] rd,
                              logic e_ifs, logic e_ms, logic e_v, logic [31:0] e_addr, logic e_we);
    vec_t v;
    v.ifr = ifr; v.ifa = ifa; v.fl = fl; v.mr = mr; v.mw = mw; v.ma = ma;
    v.rdy = rdy; v.rv = rv; v.rd = rd;
    v.e_ifs = e_ifs; v.e_ms = e_ms; v.e_v = e_v; v.e_addr = e_addr; v.e_we = e_we;
    return v;
  endfunction

  vec_t tbl [27];

  // ---------------- random-phase model state ----------------
  logic        if_pend, m_pend, m_we;
  logic [31:0] if_a, m_a, m_d;
  logic [3:0]  m_s;
  logic        slv_busy, slv_we;
  int          slv_cnt;
  logic [31:0] slv_addr;
  logic [31:0] ref_mem [16];
  logic [31:0] bus_mem [16];
  int          n_if_done, n_m_done, n_acc;

  function automatic logic [31:0] raddr();
    return 32'h0000_1000 | (32'($urandom_range(0, 15)) << 2);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // One randomized cycle: CPU-side requesters, flushes, and a memory responder.
  task automatic rand_cycle(input bit allow_new);
    logic resp_real, acc;
    @(negedge clk);
    if (allow_new && !if_pend && $urandom_range(0, 2) == 0) begin
      if_pend = 1'b1; if_a = raddr();
    end
    if (allow_new && !m_pend && $urandom_range(0, 3) == 0) begin
      m_pend = 1'b1; m_we = 1'($urandom_range(0, 1)); m_a = raddr(); m_d = $urandom;
      m_s = m_we ? 4'($urandom_range(1, 15)) : 4'h0;
    end
    flush_if = 1'b0;
    if (allow_new && if_pend && $urandom_range(0, 7) == 0) begin
      flush_if = 1'b1; if_a = raddr();
    end
    if_req = if_pend; if_addr = if_a;
    mem_req = m_pend; mem_we = m_we; mem_addr = m_a; mem_wdata = m_d; mem_wstrb = m_s;
    bus_req_ready  = 1'($urandom_range(0, 1));
    resp_real      = slv_busy && (slv_cnt == 0);
    bus_resp_valid = resp_real || (!slv_busy && $urandom_range(0, 15) == 0);
    bus_rdata      = (resp_real && !slv_we) ? bus_mem[slv_addr[5:2]] : $urandom;
    #1;
    acc = bus_req_valid && bus_req_ready;
    if (!resp_real) begin
      chk("rnd if_stall without response", if_stall, if_req);
      chk("rnd mem_stall without response", mem_stall, mem_req);
    end
    if (if_req && !if_stall) begin
      chk("rnd if_rdata", if_rdata, ref_mem[if_a[5:2]]);
      if_pend = 1'b0; n_if_done++;
    end
    if (mem_req && !mem_stall) begin
      if (m_we) ref_mem[m_a[5:2]] = merge(ref_mem[m_a[5:2]], m_d, m_s);
      else chk("rnd mem_rdata", mem_rdata, ref_mem[m_a[5:2]]);
      m_pend = 1'b0; n_m_done++;
    end
    if (resp_real) slv_busy = 1'b0;
    else if (slv_busy && slv_cnt > 0) slv_cnt--;
    if (acc) begin
      if (bus_we) begin
        chk("rnd store addr", bus_addr, m_a);
        chk("rnd store wdata", bus_wdata, m_d);
        chk("rnd store wstrb", {28'd0, bus_wstrb}, {28'd0, m_s});
        bus_mem[bus_addr[5:2]] = merge(bus_mem[bus_addr[5:2]], bus_wdata, bus_wstrb);
      end
      slv_busy = 1'b1; slv_cnt = $urandom_range(0, 5);
      slv_addr = bus_addr; slv_we = bus_we; n_acc++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  waitc;
    bit  seen;
    bit  drained;

    // ---- reset state ----
    clear_inputs();
    rst = 1'b1; if_req = 1'b1; mem_req = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("reset bus_req_valid", bus_req_valid, 0);
    chk("reset bus_addr", bus_addr, 0);
    chk("reset bus_we", bus_we, 0);
    chk("reset bus_wdata", bus_wdata, 0);
    chk("reset bus_wstrb", bus_wstrb, 0);
    chk("reset bus_err", bus_err, 0);
    chk("reset if_stall follows if_req", if_stall, 1);
    chk("reset mem_stall follows mem_req", mem_stall, 1);
    @(negedge clk);
    clear_inputs();
    rst = 1'b0;

    // ---- table: basic fetch, MEM priority + bubble, flush cases, stray responses ----
    //            ifr ifa        fl mr mw ma         rdy rv rd           ifs ms v  addr       we
    tbl[0]  = mk(1, 32'h100, 0, 0, 0, 32'h0,    1, 0, 32'h0,        1, 0, 0, 32'h0,    0);
    tbl[1]  = mk(1, 32'h100, 0, 0, 0, 32'h0,    1, 0, 32'h0,        1, 0, 1, 32'h100,  0);
    tbl[2]  = mk(1, 32'h100, 0, 0, 0, 32'h0,    0, 1, 32'h13,       0, 0, 0, 32'h100,  0);
    tbl[3]  = mk(0, 32'h0,   0, 0, 0, 32'h0,    0, 0, 32'h0,        0, 0, 0, 32'h100,  0);
    tbl[4]  = mk(1, 32'h300, 0, 1, 1, 32'h2000, 0, 0, 32'h0,        1, 1, 0, 32'h100,  0);
    tbl[5]  = mk(1, 32'h300, 0, 1, 1, 32'h2000, 1, 0, 32'h0,        1, 1, 1, 32'h2000, 1);
    tbl[6]  = mk(1, 32'h300, 0, 1, 1, 32'h2000, 0, 1, 32'h0,        1, 0, 0, 32'h2000, 1);
    tbl[7]  = mk(1, 32'h300, 0, 0, 0, 32'h0,    0, 0, 32'h0,        1, 0, 0, 32'h2000, 1);
    tbl[8]  = mk(1, 32'h300, 0, 0, 0, 32'h0,    1, 0, 32'h0,        1, 0, 1, 32'h300,  0);
    tbl[9]  = mk(1, 32'h300, 0, 0, 0, 32'h0,    0, 1, 32'hAB,       0, 0, 0, 32'h300,  0);
    tbl[10] = mk(1, 32'h400, 0, 0, 0, 32'h0,    0, 0, 32'h0,        1, 0, 0, 32'h300,  0);
    tbl[11] = mk(1, 32'h400, 0, 0, 0, 32'h0,    1, 0, 32'h0,        1, 0, 1, 32'h400,  0);
    tbl[12] = mk(1, 32'h200, 1, 0, 0, 32'h0,    0, 0, 32'h0,        1, 0, 0, 32'h400,  0);
    tbl[13] = mk(1, 32'h200, 0, 0, 0, 32'h0,    0, 1, 32'h55,       1, 0, 0, 32'h400,  0);
    tbl[14] = mk(1, 32'h200, 0, 0, 0, 32'h0,    0, 0, 32'h0,        1, 0, 0, 32'h400,  0);
    tbl[15] = mk(1, 32'h200, 0, 0, 0, 32'h0,    1, 0, 32'h0,        1, 0, 1, 32'h200,  0);
    tbl[16] = mk(1, 32'h200, 1, 0, 0, 32'h0,    0, 1, 32'h77,       1, 0, 0, 32'h200,  0);
    tbl[17] = mk(0, 32'h0,   0, 0, 0, 32'h0,    0, 0, 32'h0,        0, 0, 0, 32'h200,  0);
    tbl[18] = mk(0, 32'h0,   1, 1, 0, 32'h3000, 0, 0, 32'h0,        0, 1, 0, 32'h200,  0);
    tbl[19] = mk(0, 32'h0,   1, 1, 0, 32'h3000, 1, 0, 32'h0,        0, 1, 1, 32'h3000, 0);
    tbl[20] = mk(0, 32'h0,   1, 1, 0, 32'h3000, 0, 1, 32'h99,       0, 0, 0, 32'h3000, 0);
    tbl[21] = mk(0, 32'h0,   0, 0, 0, 32'h0,    0, 0, 32'h0,        0, 0, 0, 32'h3000, 0);
    tbl[22] = mk(1, 32'h500, 0, 0, 0, 32'h0,    0, 0, 32'h0,        1, 0, 0, 32'h3000, 0);
    tbl[23] = mk(1, 32'h500, 0, 0, 0, 32'h0,    0, 1, 32'h0,        1, 0, 1, 32'h500,  0);
    tbl[24] = mk(1, 32'h500, 0, 0, 0, 32'h0,    1, 0, 32'h0,        1, 0, 1, 32'h500,  0);
    tbl[25] = mk(1, 32'h500, 0, 0, 0, 32'h0,    0, 1, 32'h5,        0, 0, 0, 32'h500,  0);
    tbl[26] = mk(0, 32'h0,   0, 0, 0, 32'h0,    0, 1, 32'h6,        0, 0, 0, 32'h500,  0);

    for (int i = 0; i < 27; i++) begin
      @(negedge clk);
      if_req = tbl[i].ifr; if_addr = tbl[i].ifa; flush_if = tbl[i].fl;
      mem_req = tbl[i].mr; mem_we = tbl[i].mw; mem_addr = tbl[i].ma;
      mem_wdata = tbl[i].mw ? 32'hDEAD_BEEF : 32'h0;
      mem_wstrb = tbl[i].mw ? 4'hF : 4'h0;
      bus_req_ready = tbl[i].rdy; bus_resp_valid = tbl[i].rv; bus_rdata = tbl[i].rd;
      #1;
      chk($sformatf("row%0d if_stall", i), if_stall, tbl[i].e_ifs);
      chk($sformatf("row%0d mem_stall", i), mem_stall, tbl[i].e_ms);
      chk($sformatf("row%0d bus_req_valid", i), bus_req_valid, tbl[i].e_v);
      chk($sformatf("row%0d bus_addr", i), bus_addr, tbl[i].e_addr);
      chk($sformatf("row%0d bus_we", i), bus_we, tbl[i].e_we);
      chk($sformatf("row%0d bus_wstrb", i), bus_wstrb, tbl[i].e_we ? 4'hF : 4'h0);
      chk($sformatf("row%0d bus_wdata", i), bus_wdata, tbl[i].e_we ? 32'hDEAD_BEEF : 32'h0);
      chk($sformatf("row%0d if_rdata", i), if_rdata, tbl[i].rd);
      chk($sformatf("row%0d mem_rdata", i), mem_rdata, tbl[i].rd);
    end

    // ---- ready held low for 5 cycles: request stays stable ----
    @(negedge clk);
    clear_inputs();
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h4000; mem_wdata = 32'hCAFE_0001; mem_wstrb = 4'h3;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      bus_req_ready = 1'b0;
      #1;
      chk($sformatf("hold%0d bus_req_valid", k), bus_req_valid, 1);
      chk($sformatf("hold%0d bus_addr", k), bus_addr, 32'h4000);
      chk($sformatf("hold%0d bus_wdata", k), bus_wdata, 32'hCAFE_0001);
      chk($sformatf("hold%0d bus_wstrb", k), bus_wstrb, 4'h3);
    end
    @(negedge clk);
    bus_req_ready = 1'b1;
    #1;
    chk("hold accept valid", bus_req_valid, 1);
    @(negedge clk);
    bus_req_ready = 1'b0; bus_resp_valid = 1'b1;
    #1;
    chk("hold completion mem_stall", mem_stall, 0);
    @(negedge clk);
    clear_inputs();

    // ---- timeout: no response ----
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h5000; bus_req_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("timeout request valid", bus_req_valid, 1);
    waitc = 0; seen = 1'b0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      @(negedge clk);
      bus_req_ready = 1'b0; bus_rdata = 32'hFFFF_FFFF;
      #1;
      if (!mem_stall) begin
        seen = 1'b1; waitc = k;
        chk("timeout mem_rdata forced", mem_rdata, 0);
        chk("timeout bus_err before edge", bus_err, 0);
      end
    end
    chk("timeout WAIT cycles to release", waitc, TO);
    @(negedge clk);
    clear_inputs();
    #1;
    chk("timeout bus_err set", bus_err, 1);
    repeat (3) @(negedge clk);
    #1;
    chk("timeout bus_err sticky", bus_err, 1);

    // ---- reset during WAIT, late response afterwards ----
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h600;
    @(negedge clk);
    bus_req_ready = 1'b1;
    @(negedge clk);
    bus_req_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("rst-in-wait bus_req_valid", bus_req_valid, 0);
    chk("rst-in-wait if_stall", if_stall, 1);
    @(negedge clk);
    rst = 1'b0; bus_resp_valid = 1'b1; bus_rdata = 32'h1234_5678;
    #1;
    chk("late resp no release", if_stall, 1);
    chk("late resp bus_req_valid", bus_req_valid, 0);
    chk("reset clears bus_err", bus_err, 0);
    @(negedge clk);
    bus_resp_valid = 1'b0;
    #1;
    chk("after reset regrant valid", bus_req_valid, 1);
    chk("after reset regrant addr", bus_addr, 32'h600);
    @(negedge clk);
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // ---- randomized traffic against the memory model ----
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = 32'h5A00_0000 + 32'(i) * 32'h0001_0203 + 32'(i);
      bus_mem[i] = ref_mem[i];
    end
    if_pend = 1'b0; m_pend = 1'b0; m_we = 1'b0; if_a = '0; m_a = '0; m_d = '0; m_s = '0;
    slv_busy = 1'b0; slv_we = 1'b0; slv_cnt = 0; slv_addr = '0;
    n_if_done = 0; n_m_done = 0; n_acc = 0;
    for (int c = 0; c < 3000; c++) rand_cycle(1'b1);
    drained = 1'b0;
    for (int c = 0; c < 200 && !drained; c++) begin
      rand_cycle(1'b0);
      drained = !if_pend && !m_pend && !slv_busy;
    end
    chk("random drain completes", {31'd0, drained}, 1);
    chk("random no timeout", bus_err, 0);
    chk("random fetches completed", (n_if_done > 0) ? 1 : 0, 1);
    chk("random loads/stores completed", (n_m_done > 0) ? 1 : 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
